// File: rtl/ddr2_multiport_arbiter.sv
// DDR2 local-port arbiter for NUM_CH linear burst channels with tagged read return.
// Optional macro DDR2_ARB_PRIO0_EN: channel 0 preempts the round-robin when eligible.
module ddr2_multiport_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 25,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_dir,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH-1:0]        ch_ok,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_wpop,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  input  logic                     local_ready,
  output logic [ADDR_W-1:0]        local_address,
  output logic [2:0]               local_size,
  output logic                     local_burstbegin,
  output logic                     local_write_req,
  output logic                     local_read_req,
  output logic [DATA_W-1:0]        local_wdata,
  output logic [DATA_W/8-1:0]      local_be,
  input  logic [DATA_W-1:0]        local_rdata,
  input  logic                     local_rdata_valid
);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TPW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OW  = TPW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_grant;
  logic [CW-1:0]     r_last;
  logic [2:0]        r_beat;
  logic [2:0]        r_rbeat;
  logic [NUM_CH-1:0] r_busy;
  logic [NUM_CH-1:0] r_dir;
  logic [NUM_CH-1:0] r_done;
  logic [NUM_CH-1:0] r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr [NUM_CH];
  logic [LEN_W-1:0]  r_rem  [NUM_CH];
  logic [OW-1:0]     r_out  [NUM_CH];
  logic [CW-1:0]     r_tag  [TAG_DEPTH];
  logic [TPW-1:0]    r_wptr;
  logic [TPW-1:0]    r_rptr;
  logic [OW-1:0]     r_tcnt;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_rr;
  logic              w_any;
  logic [CW-1:0]     w_sel;
  logic              w_tag_full;
  logic              w_wacc;
  logic              w_wlast;
  logic              w_racc;
  logic              w_ret;
  logic              w_pop;
  logic [CW-1:0]     w_head;

  assign w_tag_full = (r_tcnt == OW'(TAG_DEPTH));
  assign w_wacc     = (r_state == S_WR) && local_ready;
  assign w_wlast    = w_wacc && (r_beat == 3'(BURST_LEN - 1));
  assign w_racc     = (r_state == S_RD) && local_ready;
  assign w_head     = r_tag[r_rptr];
  assign w_ret      = local_rdata_valid && (r_tcnt != '0);
  assign w_pop      = w_ret && (r_rbeat == 3'(BURST_LEN - 1));

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_elig[i] = r_busy[i] && (r_rem[i] != '0) && ch_ok[i] &&
                  (r_dir[i] || !w_tag_full);
  end

  // Search starts one past the last grantee so every channel gets a turn.
  always_comb begin
    int idx;
    idx   = 0;
    w_rr  = w_elig;
    w_any = 1'b0;
    w_sel = '0;
`ifdef DDR2_ARB_PRIO0_EN
    w_rr[0] = 1'b0;
`endif
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(r_last) + k) % NUM_CH;
      if (!w_any && w_rr[idx]) begin
        w_any = 1'b1;
        w_sel = CW'(idx);
      end
    end
`ifdef DDR2_ARB_PRIO0_EN
    if (w_elig[0]) begin
      w_any = 1'b1;
      w_sel = '0;
    end
`endif
  end

  always_comb begin
    local_write_req  = (r_state == S_WR);
    local_read_req   = (r_state == S_RD);
    local_burstbegin = local_read_req ||
                       (local_write_req && (r_beat == '0));
    local_address    = '0;
    local_wdata      = '0;
    if (local_write_req || local_read_req)
      local_address = r_addr[r_grant];
    if (local_write_req)
      local_wdata = ch_wdata[int'(r_grant)*DATA_W +: DATA_W];
    ch_wpop = w_wacc ? (NUM_CH'(1) << r_grant) : '0;
  end

  assign local_size = 3'(BURST_LEN);
  assign local_be   = '1;
  assign ch_rdata   = r_rdata;
  assign ch_rvalid  = r_rvalid;
  assign ch_busy    = r_busy;
  assign ch_done    = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_last   <= CW'(NUM_CH - 1);
      r_beat   <= '0;
      r_rbeat  <= '0;
      r_busy   <= '0;
      r_dir    <= '0;
      r_done   <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_tcnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_addr[i] <= '0;
        r_rem[i]  <= '0;
        r_out[i]  <= '0;
      end
      for (int t = 0; t < TAG_DEPTH; t++)
        r_tag[t] <= '0;
    end else begin
      r_done <= '0;

      unique case (r_state)
        S_IDLE: r_state <= S_ARB;
        S_ARB: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_last  <= w_sel;
            r_beat  <= '0;
            r_state <= r_dir[w_sel] ? S_WR : S_RD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WR: begin
          if (w_wacc)
            r_beat <= w_wlast ? '0 : r_beat + 3'd1;
          if (w_wlast)
            r_state <= S_IDLE;
        end
        S_RD: if (w_racc) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_start[i] && !r_busy[i]) begin
          if (ch_len[i*LEN_W +: LEN_W] == '0) begin
            r_done[i] <= 1'b1;
          end else begin
            r_busy[i] <= 1'b1;
            r_dir[i]  <= ch_dir[i];
            r_addr[i] <= ch_base[i*ADDR_W +: ADDR_W];
            r_rem[i]  <= ch_len[i*LEN_W +: LEN_W];
          end
        end
      end

      if (w_wlast || w_racc) begin
        r_addr[r_grant] <= r_addr[r_grant] + ADDR_W'(BURST_LEN);
        r_rem[r_grant]  <= r_rem[r_grant] - LEN_W'(1);
      end
      if (w_wlast && (r_rem[r_grant] == LEN_W'(1))) begin
        r_busy[r_grant] <= 1'b0;
        r_done[r_grant] <= 1'b1;
      end

      for (int i = 0; i < NUM_CH; i++)
        r_out[i] <= r_out[i]
                  + OW'(w_racc && (r_grant == CW'(i)))
                  - OW'(w_pop && (w_head == CW'(i)));

      if (w_racc) begin
        r_tag[r_wptr] <= r_grant;
        r_wptr        <= r_wptr + TPW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + TPW'(1);
      r_tcnt <= r_tcnt + OW'(w_racc) - OW'(w_pop);

      // A read channel finishes when its last outstanding burst drains.
      if (w_pop && (r_out[w_head] == OW'(1)) && (r_rem[w_head] == '0)) begin
        r_busy[w_head] <= 1'b0;
        r_done[w_head] <= 1'b1;
      end

      r_rvalid <= w_ret ? (NUM_CH'(1) << w_head) : '0;
      if (w_ret) begin
        r_rdata <= local_rdata;
        r_rbeat <= w_pop ? '0 : r_rbeat + 3'd1;
      end
    end
  end
endmodule
